// File: rtl/relm_op_loader.sv
// ReLM opcode loader: parses framed host bytes and drives the ring's
// shared opcode-memory write port, one opcode per accepted data byte.
module relm_op_loader #(
    parameter  int WID = 2,
    parameter  int WAD = 10,
    parameter  int WOP = 5,
    localparam int WA  = WAD + WID,
    localparam int NA  = ((WA + 7) / 8 < 1) ? 1 : (WA + 7) / 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rx_valid,
    input  logic [7:0]     rx_data,
    output logic           rx_ready,
    output logic           op_we_out,
    output logic [WA-1:0]  op_wa_out,
    output logic [WOP-1:0] op_d_out,
    output logic           busy_out,
    output logic           done_out,
    output logic           err_out
);

    typedef enum logic [2:0] {
        S_HUNT,
        S_ADDR,
        S_CNT,
        S_DATA,
        S_SUM
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [7:0]          idx;
    logic [8*NA-1:0]     abuf;
    logic [8*NA-1:0]     abuf_nxt;
    logic [8*NA+7:0]     ashift;
    logic [7:0]          cnt_lo;
    logic [15:0]         cnt_full;
    logic [15:0]         rem;
    logic [WA-1:0]       ptr;
    logic [7:0]          sum;
    logic [7:0]          sum_nxt;
    logic                derr;
    logic                bad_bit;
    logic                last_addr;
    logic                acc;
    logic                unused_bits;

    assign acc         = rx_valid & rx_ready;
    assign unused_bits = ^ashift;

    always_comb begin
        state_nxt = state;
        // Little-endian address: each new byte enters at the top.
        ashift    = {rx_data, abuf} >> 8;
        abuf_nxt  = ashift[8*NA-1:0];
        cnt_full  = {rx_data, cnt_lo};
        sum_nxt   = sum + rx_data;
        bad_bit   = (rx_data >> WOP) != 8'd0;
        last_addr = idx == 8'(NA - 1);
        if (acc) begin
            case (state)
                S_HUNT: if (rx_data == 8'hA5) state_nxt = S_ADDR;
                S_ADDR: if (last_addr) state_nxt = S_CNT;
                S_CNT: begin
                    if (idx != 8'd0) begin
                        state_nxt = (cnt_full == 16'd0) ? S_SUM : S_DATA;
                    end
                end
                S_DATA: if (rem == 16'd1) state_nxt = S_SUM;
                S_SUM:  state_nxt = S_HUNT;
                default: state_nxt = S_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready  <= 1'b0;
            op_we_out <= 1'b0;
            op_wa_out <= '0;
            op_d_out  <= '0;
            busy_out  <= 1'b0;
            done_out  <= 1'b0;
            err_out   <= 1'b0;
            idx       <= '0;
            abuf      <= '0;
            cnt_lo    <= '0;
            rem       <= '0;
            ptr       <= '0;
            sum       <= '0;
            derr      <= 1'b0;
        end else begin
            rx_ready  <= 1'b1;
            op_we_out <= 1'b0;
            done_out  <= 1'b0;
            if (acc) begin
                case (state)
                    S_HUNT: begin
                        if (rx_data == 8'hA5) begin
                            sum      <= '0;
                            err_out  <= 1'b0;
                            derr     <= 1'b0;
                            busy_out <= 1'b1;
                            idx      <= '0;
                        end
                    end
                    S_ADDR: begin
                        sum  <= sum_nxt;
                        abuf <= abuf_nxt;
                        if (last_addr) begin
                            ptr <= abuf_nxt[WA-1:0];
                            idx <= '0;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end
                    S_CNT: begin
                        sum <= sum_nxt;
                        if (idx == 8'd0) begin
                            cnt_lo <= rx_data;
                            idx    <= 8'd1;
                        end else begin
                            rem <= cnt_full;
                            idx <= '0;
                        end
                    end
                    S_DATA: begin
                        sum       <= sum_nxt;
                        op_we_out <= 1'b1;
                        op_wa_out <= ptr;
                        op_d_out  <= rx_data[WOP-1:0];
                        ptr       <= ptr + 1'b1;
                        rem       <= rem - 16'd1;
                        if (bad_bit) derr <= 1'b1;
                    end
                    S_SUM: begin
                        sum      <= sum_nxt;
                        err_out  <= (sum_nxt != 8'd0) | derr;
                        done_out <= 1'b1;
                        busy_out <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_relm_op_loader.sv
// Directed bench for relm_op_loader: frames, wrap, errors, gaps and
// mid-frame reset, checked against hand-computed write lists.
module tb_relm_op_loader;

    localparam int WID = 2;
    localparam int WAD = 10;
    localparam int WOP = 5;
    localparam int WA  = WAD + WID;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           rx_valid = 1'b0;
    logic [7:0]     rx_data = 8'h00;
    logic           rx_ready;
    logic           op_we_out;
    logic [WA-1:0]  op_wa_out;
    logic [WOP-1:0] op_d_out;
    logic           busy_out;
    logic           done_out;
    logic           err_out;

    relm_op_loader #(.WID(WID), .WAD(WAD), .WOP(WOP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .op_we_out(op_we_out),
        .op_wa_out(op_wa_out),
        .op_d_out (op_d_out),
        .busy_out (busy_out),
        .done_out (done_out),
        .err_out  (err_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [WA-1:0]  wq_a[$];
    logic [WOP-1:0] wq_d[$];
    int             wq_c[$];
    int             done_cnt = 0;
    int             bd_bad = 0;
    logic           err_done = 1'b0;

    always @(negedge clk) begin
        if (op_we_out) begin
            wq_a.push_back(op_wa_out);
            wq_d.push_back(op_d_out);
            wq_c.push_back(cyc);
        end
        if (done_out) begin
            done_cnt <= done_cnt + 1;
            err_done <= err_out;
            if (busy_out) bd_bad <= bd_bad + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] s[$], input bit gaps);
        foreach (s[i]) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(s[i]);
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] s[$],
                             input bit gaps, input logic [WA-1:0] ea[$],
                             input logic [WOP-1:0] ed[$], input logic eerr,
                             input bit consec);
        int wb;
        int db;
        int bb;
        wb = wq_a.size();
        db = done_cnt;
        bb = bd_bad;
        send_seq(s, gaps);
        repeat (3) @(negedge clk);
        chk({tag, ".nwr"}, wq_a.size() - wb, ed.size());
        foreach (ea[i]) begin
            if (wb + i < wq_a.size()) begin
                chk({tag, ".wa"}, wq_a[wb+i], ea[i]);
                chk({tag, ".wd"}, wq_d[wb+i], ed[i]);
                if (consec && i > 0)
                    chk({tag, ".b2b"}, wq_c[wb+i] - wq_c[wb+i-1], 1);
            end
        end
        chk({tag, ".done"}, done_cnt - db, 1);
        chk({tag, ".errdone"}, err_done, eerr);
        chk({tag, ".err"}, err_out, eerr);
        chk({tag, ".busy"}, busy_out, 0);
        chk({tag, ".busydone"}, bd_bad - bb, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".rdy"}, rx_ready, 0);
        chk({tag, ".we"}, op_we_out, 0);
        chk({tag, ".wa"}, op_wa_out, 0);
        chk({tag, ".d"}, op_d_out, 0);
        chk({tag, ".busy"}, busy_out, 0);
        chk({tag, ".done"}, done_out, 0);
        chk({tag, ".err"}, err_out, 0);
    endtask

    logic [7:0]     fr[$];
    logic [WA-1:0]  ea[$];
    logic [WOP-1:0] ed[$];
    logic [WA-1:0]  ea0[$];
    logic [WOP-1:0] ed0[$];

    initial begin
        int wb;
        #2;
        chk_reset_vals("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rdy.pre", rx_ready, 0);
        @(posedge clk);
        #1;
        chk("rdy.post", rx_ready, 1);
        @(negedge clk);

        fr = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h05, 8'h00, 8'h03, 8'h00,
               8'h01, 8'h02, 8'h1F, 8'hD6};
        ea = '{12'h005, 12'h006, 12'h007};
        ed = '{5'h01, 5'h02, 5'h1F};
        run_frame("norm", fr, 0, ea, ed, 0, 1);

        fr = '{8'hA5, 8'hFF, 8'h0F, 8'h02, 8'h00, 8'h07, 8'h08, 8'hE1};
        ea = '{12'hFFF, 12'h000};
        ed = '{5'h07, 5'h08};
        run_frame("wrap", fr, 0, ea, ed, 0, 1);
        chk("hold.wa", op_wa_out, 12'h000);
        chk("hold.d", op_d_out, 5'h08);

        fr = '{8'hA5, 8'h05, 8'h00, 8'h03, 8'h00, 8'h01, 8'h02, 8'h1F,
               8'hD5};
        ea = '{12'h005, 12'h006, 12'h007};
        ed = '{5'h01, 5'h02, 5'h1F};
        run_frame("badsum", fr, 0, ea, ed, 1, 1);

        send_byte(8'hA5);
        chk("sync.errclr", err_out, 0);
        chk("sync.busy", busy_out, 1);
        fr = '{8'h05, 8'h00, 8'h03, 8'h00, 8'h01, 8'h02, 8'h1F, 8'hD6};
        run_frame("good", fr, 0, ea, ed, 0, 1);

        fr = '{8'hA5, 8'h05, 8'h00, 8'h01, 8'h00, 8'h25, 8'hD5};
        ea = '{12'h005};
        ed = '{5'h05};
        run_frame("baddat", fr, 0, ea, ed, 1, 1);

        fr = '{8'hA5, 8'h05, 8'h00, 8'h00, 8'h00, 8'hFB};
        run_frame("n0", fr, 0, ea0, ed0, 0, 0);

        fr = '{8'hA5, 8'h05, 8'h00, 8'h03, 8'h00, 8'h01, 8'h02, 8'h1F,
               8'hD6};
        ea = '{12'h005, 12'h006, 12'h007};
        ed = '{5'h01, 5'h02, 5'h1F};
        run_frame("gaps", fr, 1, ea, ed, 0, 0);

        fr = '{8'hA5, 8'h05, 8'h00, 8'h03, 8'h00, 8'h01, 8'h02};
        wb = wq_a.size();
        send_seq(fr, 0);
        rx_valid = 1'b1;
        rx_data  = 8'h1F;
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (2) @(negedge clk);
        chk("midrst.nwr", wq_a.size() - wb, 2);
        if (wq_a.size() >= wb + 2) begin
            chk("midrst.wa1", wq_a[wb+1], 12'h006);
            chk("midrst.wd1", wq_d[wb+1], 5'h02);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst.rdy", rx_ready, 1);

        fr = '{8'hA5, 8'h05, 8'h00, 8'h03, 8'h00, 8'h01, 8'h02, 8'h1F,
               8'hD6};
        run_frame("after", fr, 0, ea, ed, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
